mpsoc_wb_burst_ram: RTL and testbench
=====================================

// Module: mpsoc_wb_burst_ram
// PURPOSE
//  Synthesisable Wishbone B3 slave RAM that replaces the behavioural memory BFM in MPI regression benches and FPGA builds.
//  Supports classic and incrementing/wrapping burst cycles, byte-lane writes, programmable read/write wait states,
//  out-of-range error responses and saturating per-beat access counters.
// PARAMETERS
//  DW             32          data width, multiple of 8 (8..128)
//  AW             32          address width (byte address)
//  MEM_SIZE_BYTES 32'h8000    memory size; mem_words = MEM_SIZE_BYTES/(DW/8), power of two
//  MEMORY_FILE    ""          $readmemh init file; empty = no init (contents X)
//  RD_LATENCY     1           wait cycles (0..7) before first read ack of a cycle
//  WR_LATENCY     0           wait cycles (0..7) before first write ack of a cycle
// PORTS
//  wb_clk_i     in   1      clock, all logic on rising edge
//  wb_rst_i     in   1      asynchronous active-high reset
//  wb_adr_i     in   AW     byte address; word index = wb_adr_i[AW-1:log2(DW/8)]
//  wb_dat_i     in   DW     write data
//  wb_sel_i     in   DW/8   byte-lane enables
//  wb_we_i      in   1      1 = write
//  wb_bte_i     in   2      00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//  wb_cti_i     in   3      000 classic, 010 incrementing burst, 111 end of burst; others treated as 000
//  wb_cyc_i     in   1      cycle valid
//  wb_stb_i     in   1      strobe
//  wb_ack_o     out  1      normal termination
//  wb_err_o     out  1      error termination (out of range)
//  wb_rty_o     out  1      retry, constant 0
//  wb_dat_o     out  DW     read data, valid while wb_ack_o=1
//  reads_o      out  32     acked read beats, saturates at 32'hFFFF_FFFF
//  writes_o     out  32     acked write beats, saturates
// BEHAVIOUR
//  Reset: FSM=IDLE, ack/err/rty=0, dat_o=0, reads_o=writes_o=0, latency counter=0; RAM contents not reset.
//  FSM states IDLE, WAIT, ACK, BURST.
//  IDLE: on cyc&stb, latch adr/we/bte; LAT = we ? WR_LATENCY : RD_LATENCY.
//    Out of range (word index >= mem_words): go to ACK with err; no write occurs.
//    Otherwise, if LAT>0: go to WAIT.
//    Otherwise, if cti=010: go to BURST.
//    Otherwise: go to ACK.
//  WAIT: counts LAT cycles, then goes to BURST (cti=010) or ACK. Drop of cyc returns to IDLE, no write.
//  ACK: registered ack (or err) high exactly one cycle; the write commits on this edge; returns to IDLE.
//    Classic throughput = 2+LAT cycles/beat.
//  BURST: wb_ack_o = cyc&stb (combinational qualification of the registered state).
//    Each acked beat writes (per sel) or returns data for the current internal address.
//    The internal address then advances:
//      linear: +DW/8.
//      wrapN: low log2(N*DW/8) bits increment modulo N beats, upper bits held.
//    stb low in BURST: no ack, address held, no latency re-applied.
//    Beat acked with cti=111 ends the burst -> IDLE.
//    cyc low -> IDLE immediately.
//    An advanced address that goes out of range -> err for that beat, no write, then IDLE.
//  Read data: synchronous RAM with prefetch of the next burst address, so back-to-back burst reads have zero bubbles.
//    dat_o is 0 when ack is low, and bytes with sel=0 read as 0.
//  Writes: only lanes with sel=1 are updated; sel=0 on a write still acks.
//  Counters: +1 per acked beat (not err), by direction; hold at max.
//  Reset asserted mid-cycle: all outputs reset asynchronously, no pending write commits.
//  wb_rty_o is never asserted.
// TESTING
//  1. RD_LATENCY=2: classic write 0xDEADBEEF @0x10 sel=F, then read @0x10
//     -> read ack 3 cycles after stb sampled, dat_o=0xDEADBEEF; writes_o=1, reads_o=1.
//  2. Write sel=0011 data 0x12345678 over 0xFFFFFFFF @0x20
//     -> read returns 0xFFFF5678.
//  3. Read burst cti=010 bte=01 start 0x38, 4 beats, last with cti=111
//     -> addresses 0x38, 0x3C, 0x30, 0x34; ack continuous after RD_LATENCY; FSM IDLE after beat 4.
//  4. Linear burst write 8 beats with stb low on beat 3 for 2 cycles
//     -> no ack while stb low; 8 sequential words written; writes_o=8.
//  5. Classic access @MEM_SIZE_BYTES -> err_o one cycle, ack_o=0, counters unchanged, RAM unchanged.
//  6. Assert wb_rst_i in WAIT of a write -> ack/err=0 immediately, target word unchanged, counters 0.

Source files
------------

// File: rtl/mpsoc_wb_burst_ram.sv
// Wishbone B3 slave RAM: classic and incrementing/wrapping bursts, byte lanes,
// programmable read/write wait states, out-of-range error termination and
// saturating per-direction beat counters.
module mpsoc_wb_burst_ram #(
  parameter int unsigned DW             = 32,
  parameter int unsigned AW             = 32,
  parameter int unsigned MEM_SIZE_BYTES = 32'h8000,
  parameter              MEMORY_FILE    = "",
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned WR_LATENCY     = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic [1:0]      wb_bte_i,
  input  logic [2:0]      wb_cti_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [31:0]     reads_o,
  output logic [31:0]     writes_o
);

  localparam int unsigned BYTES     = DW / 8;
  localparam int unsigned WB        = $clog2(BYTES);
  localparam int unsigned MEM_WORDS = MEM_SIZE_BYTES / BYTES;
  localparam int unsigned MW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [AW-1:0] LIMIT   = AW'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

  state_t        st_q, st_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic          burst_q, burst_d;
  logic [1:0]    bte_q, bte_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   reads_q, reads_d, writes_q, writes_d;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] mem [MEM_WORDS];

  logic          req, oor_in, oor_q, ack, err;
  logic [2:0]    lat;
  logic [AW-1:0] wrap_mask, adr_next;
  logic [DW-1:0] lane_mask;

  // Expand byte-lane selects into a bit mask for write merge and read gating.
  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < BYTES; i++)
      lane_mask[8*i +: 8] = {8{wb_sel_i[i]}};
  end

  // Next burst address: linear increments, wrapN only cycles the low beat bits.
  always_comb begin
    unique case (bte_q)
      2'b01:   wrap_mask = AW'(4 * BYTES - 1);
      2'b10:   wrap_mask = AW'(8 * BYTES - 1);
      2'b11:   wrap_mask = AW'(16 * BYTES - 1);
      default: wrap_mask = '0;
    endcase
    if (bte_q == 2'b00)
      adr_next = adr_q + AW'(BYTES);
    else
      adr_next = (adr_q & ~wrap_mask) | ((adr_q + AW'(BYTES)) & wrap_mask);
  end

  // Next-state, terminations and counter updates.
  always_comb begin
    req    = wb_cyc_i & wb_stb_i;
    oor_in = (wb_adr_i >> WB) >= LIMIT;
    oor_q  = (adr_q >> WB) >= LIMIT;
    lat    = wb_we_i ? 3'(WR_LATENCY) : 3'(RD_LATENCY);

    ack = 1'b0;
    err = 1'b0;
    unique case (st_q)
      ACK: begin
        ack = ~err_q;
        err = err_q;
      end
      BURST: begin
        ack = req & ~oor_q;
        err = req & oor_q;
      end
      default: ;
    endcase

    st_d    = st_q;
    adr_d   = adr_q;
    we_d    = we_q;
    err_d   = err_q;
    burst_d = burst_q;
    bte_d   = bte_q;
    cnt_d   = cnt_q;
    unique case (st_q)
      IDLE: begin
        if (req) begin
          adr_d   = wb_adr_i;
          we_d    = wb_we_i;
          bte_d   = wb_bte_i;
          burst_d = (wb_cti_i == 3'b010);
          err_d   = oor_in;
          if (oor_in) begin
            st_d = ACK;
          end else if (lat != 3'd0) begin
            st_d  = WAIT;
            cnt_d = lat - 3'd1;
          end else if (wb_cti_i == 3'b010) begin
            st_d = BURST;
          end else begin
            st_d = ACK;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i)
          st_d = IDLE;
        else if (cnt_q == 3'd0)
          st_d = burst_q ? BURST : ACK;
        else
          cnt_d = cnt_q - 3'd1;
      end
      ACK: st_d = IDLE;
      BURST: begin
        if (!wb_cyc_i || err) begin
          st_d = IDLE;
        end else if (ack) begin
          adr_d = adr_next;
          if (wb_cti_i != 3'b010)
            st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase

    reads_d  = (ack && !we_q && reads_q != '1) ? reads_q + 32'd1 : reads_q;
    writes_d = (ack && we_q && writes_q != '1) ? writes_q + 32'd1 : writes_q;
  end

  // Control state and counters; asynchronous reset leaves RAM contents alone.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      st_q     <= IDLE;
      adr_q    <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      burst_q  <= 1'b0;
      bte_q    <= 2'b00;
      cnt_q    <= '0;
      reads_q  <= '0;
      writes_q <= '0;
    end else begin
      st_q     <= st_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      err_q    <= err_d;
      burst_q  <= burst_d;
      bte_q    <= bte_d;
      cnt_q    <= cnt_d;
      reads_q  <= reads_d;
      writes_q <= writes_d;
    end
  end

  // RAM port: byte-merged write on acked write beats; read follows the
  // next-cycle address so burst reads are prefetched without bubbles.
  always_ff @(posedge wb_clk_i) begin
    if (ack && we_q)
      mem[adr_q[WB +: MW]] <= (mem[adr_q[WB +: MW]] & ~lane_mask) | (wb_dat_i & lane_mask);
    rdata_q <= mem[adr_d[WB +: MW]];
  end

  assign wb_ack_o = ack;
  assign wb_err_o = err;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = (ack && !we_q) ? (rdata_q & lane_mask) : '0;
  assign reads_o  = reads_q;
  assign writes_o = writes_q;

endmodule

// File: tb/tb_mpsoc_wb_burst_ram.sv
// Directed and randomized checks of mpsoc_wb_burst_ram against a word-array
// memory model with spec-level latency and address-sequence rules.
module tb_mpsoc_wb_burst_ram;

  localparam int unsigned MEM_BYTES = 32'h400;
  localparam int unsigned WORDS     = MEM_BYTES / 4;
  localparam int unsigned RD_LAT    = 2;
  localparam int unsigned WR_LAT    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic [1:0]  bte = '0;
  logic [2:0]  cti = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        ack, err, rty;
  logic [31:0] dat_o, reads, writes;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] mdl [WORDS];
  int unsigned exp_reads = 0;
  int unsigned exp_writes = 0;

  mpsoc_wb_burst_ram #(
    .DW(32), .AW(32), .MEM_SIZE_BYTES(MEM_BYTES), .MEMORY_FILE(""),
    .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_sel_i(sel), .wb_we_i(we), .wb_bte_i(bte), .wb_cti_i(cti),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack), .wb_err_o(err),
    .wb_rty_o(rty), .wb_dat_o(dat_o), .reads_o(reads), .writes_o(writes)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return (a / 4) < WORDS;
  endfunction

  function automatic logic [31:0] burst_addr(input logic [31:0] s, input logic [1:0] b,
                                             input int unsigned k);
    logic [31:0] span;
    case (b)
      2'b01:   span = 32'd16;
      2'b10:   span = 32'd32;
      default: span = 32'd64;
    endcase
    if (b == 2'b00) return s + 32'(4 * k);
    return (s - s % span) + ((s % span + 32'(4 * k)) % span);
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int l = 0; l < 4; l++) if (s[l]) mdl[a[9:2]][8*l +: 8] = d[8*l +: 8];
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, ":reads"}, reads, exp_reads);
    chk({tag, ":writes"}, writes, exp_writes);
  endtask

  task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input string tag, output logic [31:0] rd);
    int unsigned n, lat;
    bit ok;
    logic got_ack, got_err;
    ok = in_range(a);
    lat = w ? WR_LAT : RD_LAT;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s; cti = 3'b000; bte = 2'b00;
    n = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0;
    while (n < 20) begin
      #1;
      if (ack || err) begin
        got_ack = ack; got_err = err; rd = dat_o;
        break;
      end
      next_cycle();
      n++;
    end
    chk({tag, ":wait"}, n, ok ? lat + 1 : 1);
    chk({tag, ":ack"}, 32'(got_ack), 32'(ok));
    chk({tag, ":err"}, 32'(got_err), 32'(!ok));
    if (!ok) chk({tag, ":dat0"}, rd, '0);
    else if (!w) chk({tag, ":data"}, rd, mdl[a[9:2]] & lanes(s));
    if (ok) begin
      if (w) begin mdl_write(a, d, s); exp_writes++; end
      else exp_reads++;
    end
    next_cycle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk_counters(tag);
  endtask

  task automatic burst(input logic w, input logic [31:0] start, input int unsigned nb,
                       input logic [1:0] b, input int unsigned stall_at,
                       input int unsigned stall_len, input bit rnd_sel, input string tag);
    int unsigned beat, waited, stalled, budget, exp_done, lat;
    logic [31:0] a, d;
    logic [3:0] s;
    bit stalling, done;
    lat = w ? WR_LAT : RD_LAT;
    exp_done = 0;
    while (exp_done < nb && in_range(burst_addr(start, b, exp_done))) exp_done++;
    beat = 0; waited = 0; stalled = 0; budget = 0; done = 0;
    cyc = 1'b1; we = w; bte = b;
    while (!done && budget < 300) begin
      a = burst_addr(start, b, beat);
      stalling = (beat == stall_at) && (stalled < stall_len);
      s = rnd_sel ? 4'($urandom) : 4'hF;
      d = $urandom;
      stb = !stalling; adr = a; sel = s; dat_i = d;
      cti = (beat == nb - 1) ? 3'b111 : 3'b010;
      #1;
      if (stalling) begin
        chk({tag, ":stall"}, 32'({ack, err}), 32'd0);
        stalled++;
      end else if (!in_range(a)) begin
        if (ack || err) begin
          chk({tag, ":oor_term"}, 32'({ack, err}), 32'b01);
          chk({tag, ":oor_wait"}, waited, 0);
          done = 1;
        end else waited++;
      end else if (ack || err) begin
        chk({tag, ":term"}, 32'({ack, err}), 32'b10);
        chk({tag, ":wait"}, waited, beat == 0 ? lat + 1 : 0);
        if (w) begin mdl_write(a, d, s); exp_writes++; end
        else begin
          chk({tag, ":data"}, dat_o, mdl[a[9:2]] & lanes(s));
          exp_reads++;
        end
        waited = 0;
        beat++;
        if (beat == nb) done = 1;
      end else waited++;
      next_cycle();
      budget++;
    end
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; we = 1'b0;
    chk({tag, ":beats"}, beat, exp_done);
    chk_counters(tag);
  endtask

  initial begin
    logic [31:0] rd, a, w0, r0;
    int unsigned nb, st;

    repeat (3) @(posedge clk);
    #1;
    chk("rst:ack", 32'(ack), 32'd0);
    chk("rst:err", 32'(err), 32'd0);
    chk("rst:rty", 32'(rty), 32'd0);
    chk("rst:dat", dat_o, 32'd0);
    chk_counters("rst");
    rst = 1'b0;
    next_cycle();

    // Classic write then read with read latency 2.
    classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "t1_wr", rd);
    classic(1'b0, 32'h10, 32'h0, 4'hF, "t1_rd", rd);
    chk("t1_rd_const", rd, 32'hDEADBEEF);
    chk("t1_writes", writes, 32'd1);
    chk("t1_reads", reads, 32'd1);

    // Partial byte-lane write.
    classic(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, "t2_wr_full", rd);
    classic(1'b1, 32'h20, 32'h12345678, 4'b0011, "t2_wr_part", rd);
    classic(1'b0, 32'h20, 32'h0, 4'hF, "t2_rd", rd);
    chk("t2_rd_const", rd, 32'hFFFF5678);

    // Fill the whole RAM with random data through one linear burst.
    burst(1'b1, 32'h0, WORDS, 2'b00, WORDS, 0, 1'b0, "fill");

    // Wrap4 read burst starting mid-block.
    burst(1'b0, 32'h38, 4, 2'b01, 4, 0, 1'b0, "t3_wrap4");

    // Linear write burst with a two-cycle strobe gap on the third beat.
    w0 = writes;
    burst(1'b1, 32'h80, 8, 2'b00, 2, 2, 1'b0, "t4_wr");
    chk("t4_writes_delta", writes - w0, 32'd8);
    burst(1'b0, 32'h80, 8, 2'b00, 8, 0, 1'b0, "t4_rd");

    // Out-of-range classic accesses; word 0 aliases the truncated index.
    r0 = reads; w0 = writes;
    classic(1'b0, MEM_BYTES, 32'h0, 4'hF, "t5_rd", rd);
    classic(1'b1, MEM_BYTES, 32'h5A5A5A5A, 4'hF, "t5_wr", rd);
    chk("t5_reads_same", reads, r0);
    chk("t5_writes_same", writes, w0);
    classic(1'b0, 32'h0, 32'h0, 4'hF, "t5_word0", rd);

    // Linear bursts that run off the end of memory.
    burst(1'b0, MEM_BYTES - 8, 4, 2'b00, 4, 0, 1'b0, "oor_rd");
    burst(1'b1, MEM_BYTES - 4, 3, 2'b00, 3, 0, 1'b1, "oor_wr");
    classic(1'b0, 32'h0, 32'h0, 4'hF, "oor_word0", rd);
    classic(1'b0, MEM_BYTES - 4, 32'h0, 4'hF, "oor_last", rd);

    // Randomized mix of classic and burst traffic.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 32'($urandom_range(0, WORDS + 7)) * 4;
        classic(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), "rnd_cl", rd);
      end else begin
        nb = $urandom_range(1, 16);
        st = ($urandom_range(0, 2) == 0) ? nb : $urandom_range(1, nb);
        a = 32'($urandom_range(0, WORDS - 1)) * 4;
        burst(1'($urandom_range(0, 1)), a, nb, 2'($urandom), st, $urandom_range(1, 3),
              1'b1, "rnd_bu");
      end
      chk("rnd_rty", 32'(rty), 32'd0);
    end

    // Asynchronous reset while a write is in its wait state.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h44; dat_i = 32'hA5A5A5A5;
    sel = 4'hF; cti = 3'b000; bte = 2'b00;
    next_cycle();
    rst = 1'b1;
    #1;
    exp_reads = 0; exp_writes = 0;
    chk("t6:ack", 32'(ack), 32'd0);
    chk("t6:err", 32'(err), 32'd0);
    chk("t6:dat", dat_o, 32'd0);
    chk_counters("t6");
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    classic(1'b0, 32'h44, 32'h0, 4'hF, "t6_word", rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
